// File: rtl/std_cache_pkg.sv
// Shared types for the standard data cache bypass path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package std_cache_pkg;

    localparam int BYPASS_ID_WIDTH = 4;

    typedef struct packed {
        logic                       req;
        logic                       we;
        logic [7:0]                 be;
        logic [1:0]                 size;
        logic [BYPASS_ID_WIDTH-1:0] id;
        logic [63:0]                addr;
        logic [63:0]                wdata;
    } bypass_req_t;

    typedef struct packed {
        logic        gnt;
        logic        valid;
        logic [63:0] rdata;
    } bypass_rsp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } bypass_arb_state_e;

endpackage

// File: rtl/std_bypass_rr_pick.sv
// Round-robin picker: first set request bit at or above the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module std_bypass_rr_pick #(
    parameter int NR_PORTS = 3,
    localparam int IDX_W   = $clog2(NR_PORTS)
) (
    input  logic [NR_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]    rr_i,
    output logic                any_o,
    output logic [IDX_W-1:0]    idx_o
);

    logic              found;
    logic [31:0]       cand;
    logic [IDX_W-1:0]  cand_idx;

    // Scan NR_PORTS candidates starting at the pointer; first hit wins.
    always_comb begin
        any_o    = |req_i;
        idx_o    = '0;
        found    = 1'b0;
        cand     = '0;
        cand_idx = '0;
        for (int k = 0; k < NR_PORTS; k++) begin
            cand = 32'(rr_i) + 32'(k);
            if (cand >= 32'(NR_PORTS)) begin
                cand = cand - 32'(NR_PORTS);
            end
            cand_idx = IDX_W'(cand);
            if (!found && req_i[cand_idx]) begin
                found = 1'b1;
                idx_o = cand_idx;
            end
        end
    end

endmodule

// File: rtl/std_bypass_arbiter.sv
// Shares the single bypass memory port among NR_PORTS requesters, one access in flight.
// Latency: requester gnt same cycle, downstream req next cycle, response routed combinationally.
// Backpressure: holds the captured request until the adapter grants; no new capture until the response returns.
module std_bypass_arbiter
    import std_cache_pkg::*;
#(
    parameter int NR_PORTS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  bypass_req_t [NR_PORTS-1:0] req_i,
    output bypass_rsp_t [NR_PORTS-1:0] rsp_o,
    output bypass_req_t                bypass_req_o,
    input  bypass_rsp_t                bypass_rsp_i
);

    localparam int IDX_W = $clog2(NR_PORTS);

    bypass_arb_state_e state_q, state_d;
    bypass_req_t       req_q, req_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  rr_q, rr_d;

    logic [NR_PORTS-1:0] req_vec;
    logic                pick_any;
    logic [IDX_W-1:0]    pick_idx;

    // Flatten the per-port request strobes for the picker.
    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            req_vec[i] = req_i[i].req;
        end
    end

    std_bypass_rr_pick #(
        .NR_PORTS (NR_PORTS)
    ) u_pick (
        .req_i (req_vec),
        .rr_i  (rr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // Next state and outputs; everything is held quiet while reset is asserted.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        idx_d        = idx_q;
        rr_d         = rr_q;
        rsp_o        = '0;
        bypass_req_o = '0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        rsp_o[pick_idx].gnt = 1'b1;
                        req_d   = req_i[pick_idx];
                        idx_d   = pick_idx;
                        rr_d    = (pick_idx == IDX_W'(NR_PORTS - 1)) ? '0 : pick_idx + 1'b1;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    bypass_req_o     = req_q;
                    bypass_req_o.req = 1'b1;
                    bypass_req_o.id  = BYPASS_ID_WIDTH'(idx_q);
                    if (bypass_rsp_i.gnt) begin
                        if (bypass_rsp_i.valid) begin
                            // Adapter answered in the grant cycle: deliver now.
                            rsp_o[idx_q].valid = 1'b1;
                            rsp_o[idx_q].rdata = bypass_rsp_i.rdata;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Loads and store acknowledges both complete on valid.
                    if (bypass_rsp_i.valid) begin
                        rsp_o[idx_q].valid = 1'b1;
                        rsp_o[idx_q].rdata = bypass_rsp_i.rdata;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, captured request, winner index and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding, or a grant with nothing offered, is dropped.
    stray_rsp_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !((bypass_rsp_i.valid && state_q == IDLE) || (bypass_rsp_i.gnt && state_q != REQ)))
        else $warning("stray bypass response ignored");
`endif

endmodule

// File: tb/tb_std_bypass_arbiter.sv
module tb_std_bypass_arbiter;
    import std_cache_pkg::*;

    localparam int NP = 3;

    logic                  clk = 1'b0;
    logic                  rst_i;
    bypass_req_t [NP-1:0]  req_i;
    bypass_rsp_t [NP-1:0]  rsp_o;
    bypass_req_t           bypass_req_o;
    bypass_rsp_t           bypass_rsp_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    std_bypass_arbiter #(.NR_PORTS(NP)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .rsp_o        (rsp_o),
        .bypass_req_o (bypass_req_o),
        .bypass_rsp_i (bypass_rsp_i)
    );

    typedef struct {
        int          port;
        logic [63:0] rdata;
    } rsp_exp_t;

    int          gnt_q[$];
    rsp_exp_t    rsp_q[$];
    bypass_req_t ds_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bypass_req_t mk(input logic we, input logic [7:0] be,
                                       input logic [63:0] addr, input logic [63:0] wdata);
        bypass_req_t r;
        r       = '0;
        r.req   = 1'b1;
        r.we    = we;
        r.be    = be;
        r.size  = 2'd3;
        r.id    = 4'hA;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic bypass_req_t dsx(input bypass_req_t r, input int p);
        bypass_req_t e;
        e     = r;
        e.req = 1'b1;
        e.id  = 4'(p);
        return e;
    endfunction

    // Monitor: pops expectations whenever the DUT presents gnt, valid or a downstream handshake.
    int          mon_ng, mon_nv, mon_gp, mon_vp, mon_e;
    logic        mon_gate;
    rsp_exp_t    mon_r;
    bypass_req_t mon_d;
    always @(negedge clk) begin
        if (!rst_i) begin
            mon_ng = 0; mon_nv = 0; mon_gp = 0; mon_vp = 0; mon_gate = 1'b1;
            for (int j = 0; j < NP; j++) begin
                if (rsp_o[j].gnt) begin mon_ng++; mon_gp = j; end
                if (rsp_o[j].valid) begin mon_nv++; mon_vp = j; end
                else if (rsp_o[j].rdata != '0) mon_gate = 1'b0;
            end
            checks++;
            if (!mon_gate) begin
                errors++; $display("FAIL rdata_gate actual=nonzero required=zero");
            end
            if (mon_ng > 1) begin
                errors++; $display("FAIL gnt_onehot actual=%0d required=1", mon_ng);
            end else if (mon_ng == 1) begin
                checks++;
                if (gnt_q.size() == 0) begin
                    errors++; $display("FAIL gnt_unexpected actual=port%0d required=none", mon_gp);
                end else begin
                    mon_e = gnt_q.pop_front();
                    if (mon_e != mon_gp) begin
                        errors++; $display("FAIL gnt_port actual=%0d required=%0d", mon_gp, mon_e);
                    end
                end
            end
            if (mon_nv > 1) begin
                errors++; $display("FAIL valid_onehot actual=%0d required=1", mon_nv);
            end else if (mon_nv == 1) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++; $display("FAIL valid_unexpected actual=port%0d required=none", mon_vp);
                end else begin
                    mon_r = rsp_q.pop_front();
                    if (mon_r.port != mon_vp || rsp_o[mon_vp].rdata !== mon_r.rdata) begin
                        errors++;
                        $display("FAIL rsp actual=port%0d/%h required=port%0d/%h",
                                 mon_vp, rsp_o[mon_vp].rdata, mon_r.port, mon_r.rdata);
                    end
                end
            end
            if (bypass_req_o.req && bypass_rsp_i.gnt) begin
                checks++;
                if (ds_q.size() == 0) begin
                    errors++; $display("FAIL ds_unexpected actual=%h required=none", bypass_req_o);
                end else begin
                    mon_d = ds_q.pop_front();
                    if (bypass_req_o !== mon_d) begin
                        errors++; $display("FAIL ds_payload actual=%h required=%h", bypass_req_o, mon_d);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    bypass_req_t r;
    int          p;

    initial begin
        rst_i        = 1'b1;
        req_i        = '0;
        bypass_rsp_i = '0;
        step();
        @(negedge clk);
        chk("rst_rsp_zero", 64'(|rsp_o), 64'd0);
        chk("rst_ds_zero", 64'(|bypass_req_o), 64'd0);
        step();
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_rsp_zero", 64'(|rsp_o), 64'd0);
        chk("idle_ds_zero", 64'(|bypass_req_o), 64'd0);

        // Contention: all ports request continuously, gnt+valid together in REQ.
        step();
        for (int k = 0; k < NP; k++) req_i[k] = mk(1'b0, 8'hFF, 64'h1000 + 64'(k * 16), 64'd0);
        for (int n = 0; n < 5; n++) begin
            p = n % NP;
            gnt_q.push_back(p);
            ds_q.push_back(dsx(req_i[p], p));
            rsp_q.push_back('{p, 64'hC0DE_0000 + 64'(n)});
            @(negedge clk);
            chk("cont_gnt_2cyc", 64'(rsp_o[p].gnt), 64'd1);
            step();
            bypass_rsp_i.gnt   = 1'b1;
            bypass_rsp_i.valid = 1'b1;
            bypass_rsp_i.rdata = 64'hC0DE_0000 + 64'(n);
            @(negedge clk);
            chk("cont_same_cycle_valid", 64'(rsp_o[p].valid), 64'd1);
            step();
            bypass_rsp_i = '0;
            if (n == 4) req_i = '0;
        end

        // Single load on port 1 with adapter gnt at cycle 2 and valid at cycle 4.
        r = mk(1'b0, 8'hFF, 64'h8000_0010, 64'd0);
        req_i[1] = r;
        gnt_q.push_back(1); ds_q.push_back(dsx(r, 1)); rsp_q.push_back('{1, 64'hDEAD_BEEF});
        @(negedge clk);
        chk("load_gnt_c0", 64'(rsp_o[1].gnt), 64'd1);
        chk("load_no_ds_c0", 64'(bypass_req_o.req), 64'd0);
        step();
        req_i[1] = '0;
        @(negedge clk);
        chk("load_req_c1", 64'(bypass_req_o.req), 64'd1);
        chk("load_id_c1", 64'(bypass_req_o.id), 64'd1);
        step();
        bypass_rsp_i.gnt = 1'b1;
        step();
        bypass_rsp_i.gnt = 1'b0;
        @(negedge clk);
        chk("load_wait_req_low", 64'(bypass_req_o.req), 64'd0);
        chk("load_wait_no_valid", 64'(rsp_o[1].valid), 64'd0);
        step();
        bypass_rsp_i.valid = 1'b1;
        bypass_rsp_i.rdata = 64'hDEAD_BEEF;
        @(negedge clk);
        chk("load_valid_c4", 64'(rsp_o[1].valid), 64'd1);
        chk("load_rdata_c4", rsp_o[1].rdata, 64'hDEAD_BEEF);
        chk("load_others_zero", 64'(|{rsp_o[0], rsp_o[2]}), 64'd0);
        step();
        bypass_rsp_i = '0;

        // Store on port 2; completes on the write acknowledge.
        r = mk(1'b1, 8'h0F, 64'h8000_0100, 64'h1122_3344_5566_7788);
        req_i[2] = r;
        gnt_q.push_back(2); ds_q.push_back(dsx(r, 2)); rsp_q.push_back('{2, 64'd0});
        step();
        req_i[2] = '0;
        bypass_rsp_i.gnt = 1'b1;
        @(negedge clk);
        chk("store_id", 64'(bypass_req_o.id), 64'd2);
        chk("store_we_be", {55'd0, bypass_req_o.we, bypass_req_o.be}, {55'd0, 1'b1, 8'h0F});
        chk("store_wdata", bypass_req_o.wdata, 64'h1122_3344_5566_7788);
        step();
        bypass_rsp_i = '0;
        @(negedge clk);
        chk("store_wait_no_valid", 64'(rsp_o[2].valid), 64'd0);
        step();
        bypass_rsp_i.valid = 1'b1;
        @(negedge clk);
        chk("store_ack_valid", 64'(rsp_o[2].valid), 64'd1);
        step();
        bypass_rsp_i = '0;

        // Stray valid in IDLE is dropped and the FSM stays in IDLE.
        bypass_rsp_i.valid = 1'b1;
        bypass_rsp_i.rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("stray_no_valid", 64'(rsp_o[0].valid | rsp_o[1].valid | rsp_o[2].valid), 64'd0);
        step();
        bypass_rsp_i = '0;
        r = mk(1'b0, 8'hFF, 64'h8000_0200, 64'd0);
        req_i[0] = r;
        gnt_q.push_back(0); ds_q.push_back(dsx(r, 0)); rsp_q.push_back('{0, 64'h55});
        @(negedge clk);
        chk("stray_then_gnt", 64'(rsp_o[0].gnt), 64'd1);
        step();
        req_i[0] = '0;
        bypass_rsp_i.gnt = 1'b1; bypass_rsp_i.valid = 1'b1; bypass_rsp_i.rdata = 64'h55;
        step();
        bypass_rsp_i = '0;
        @(negedge clk);
        chk("idle_after_gv", 64'(bypass_req_o.req), 64'd0);

        // Reset while in WAIT abandons the access; pointer returns to 0.
        step();
        r = mk(1'b0, 8'hFF, 64'h8000_0300, 64'd0);
        req_i[0] = r;
        gnt_q.push_back(0); ds_q.push_back(dsx(r, 0));
        step();
        req_i[0] = '0;
        bypass_rsp_i.gnt = 1'b1;
        step();
        bypass_rsp_i = '0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk);
        chk("postrst_rsp_zero", 64'(|rsp_o), 64'd0);
        chk("postrst_ds_zero", 64'(|bypass_req_o), 64'd0);
        step();
        bypass_rsp_i.valid = 1'b1;
        bypass_rsp_i.rdata = 64'h1234;
        @(negedge clk);
        chk("postrst_stray_ignored", 64'(rsp_o[0].valid), 64'd0);
        step();
        bypass_rsp_i = '0;
        req_i[0] = mk(1'b0, 8'hFF, 64'h8000_0400, 64'd0);
        req_i[2] = mk(1'b0, 8'hFF, 64'h8000_0500, 64'd0);
        gnt_q.push_back(0); ds_q.push_back(dsx(req_i[0], 0)); rsp_q.push_back('{0, 64'h77});
        @(negedge clk);
        chk("postrst_rr_zero", 64'(rsp_o[0].gnt), 64'd1);
        step();
        req_i[0] = '0;
        bypass_rsp_i.gnt = 1'b1; bypass_rsp_i.valid = 1'b1; bypass_rsp_i.rdata = 64'h77;
        step();
        bypass_rsp_i = '0;
        gnt_q.push_back(2); ds_q.push_back(dsx(req_i[2], 2)); rsp_q.push_back('{2, 64'h88});
        @(negedge clk);
        chk("postrst_next_port2", 64'(rsp_o[2].gnt), 64'd1);
        step();
        req_i[2] = '0;
        bypass_rsp_i.gnt = 1'b1; bypass_rsp_i.valid = 1'b1; bypass_rsp_i.rdata = 64'h88;
        step();
        bypass_rsp_i = '0;
        repeat (3) step();

        chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        chk("ds_q_drained", 64'(ds_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
